// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch sequencer for the 16-bit single-cycle MIPS core.
// Drives the instruction-memory word address, selects the next pc from
// sequential, branch and jump requests, tracks BOOT/RUN/HALT and counts
// retired instructions (saturating).
module pc_fetch_unit #(
  parameter int PC_WIDTH   = 16,
  parameter int RESET_PC   = 0,
  parameter int MEM_DEPTH  = 16,
  parameter int BOFF_WIDTH = 6,
  parameter int JTGT_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [BOFF_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic [JTGT_WIDTH-1:0] jump_target,
  input  logic                  halt_req,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   pc_plus1,
  output logic                  fetch_valid,
  output logic                  halted,
  output logic [15:0]           retired_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  // One extra bit so MEM_DEPTH == 2^PC_WIDTH (no halting range) is representable.
  localparam logic [PC_WIDTH:0]   LP_LIMIT = (PC_WIDTH+1)'(MEM_DEPTH);
  localparam logic [PC_WIDTH-1:0] LP_RST   = PC_WIDTH'(RESET_PC);

  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic                r_fv, r_halted;

  logic [PC_WIDTH-1:0] w_pc_plus1, w_boff_sext, w_br_pc, w_jmp_pc, w_target;
  logic [15:0]         w_cnt_inc;
  logic                w_out_of_range;

  assign w_pc_plus1  = r_pc + PC_WIDTH'(1);
  assign w_boff_sext = {{(PC_WIDTH-BOFF_WIDTH){branch_offset[BOFF_WIDTH-1]}}, branch_offset};
  assign w_br_pc     = w_pc_plus1 + w_boff_sext;
  assign w_jmp_pc    = {w_pc_plus1[PC_WIDTH-1:JTGT_WIDTH], jump_target};
  // Jump outranks branch; a simultaneous branch is simply dropped.
  assign w_target    = jump ? w_jmp_pc : (branch_taken ? w_br_pc : w_pc_plus1);
  assign w_out_of_range = ({1'b0, w_target} >= LP_LIMIT);
  assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + 16'd1;

  // Next-state / next-pc / next-count selection with RUN priority
  // halt_req > stall > jump > branch > sequential.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (halt_req) begin
          w_cnt_nxt   = w_cnt_inc;
          w_state_nxt = S_HALT;
        end else if (!stall) begin
          w_cnt_nxt = w_cnt_inc;
          w_pc_nxt  = w_target;
          // The out-of-range address is loaded but never marked valid.
          if (w_out_of_range) w_state_nxt = S_HALT;
        end
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // State, pc, counter and registered status flags; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_BOOT;
      r_pc     <= LP_RST;
      r_cnt    <= 16'd0;
      r_fv     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fv     <= (w_state_nxt == S_RUN);
      r_halted <= (w_state_nxt == S_HALT);
    end
  end

  assign pc            = r_pc;
  assign pc_plus1      = w_pc_plus1;
  assign fetch_valid   = r_fv;
  assign halted        = r_halted;
  assign retired_count = r_cnt;

endmodule
